// File: rtl/miriscv_pkg.sv
// rtl/miriscv_pkg.sv - shared state, owner and counter definitions for the memory arbiter
package miriscv_pkg;

  // Arbiter FSM states
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Owner of the outstanding access; the value doubles as the picker's pointer encoding
  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } arb_owner_e;

  // Latency counter width, enough for MEM_LATENCY up to 4
  localparam int ARB_CNT_W = 2;

  // Bit positions of the two requesters in the picker's req/gnt vectors
  localparam int ARB_REQ_INSTR = 0;
  localparam int ARB_REQ_DATA  = 1;

  // Counter value loaded at grant so that it reaches zero on the response cycle
  function automatic logic [ARB_CNT_W-1:0] arb_cnt_init(input int latency);
    arb_cnt_init = ARB_CNT_W'(latency - 1);
  endfunction

endpackage

// File: rtl/miriscv_mem_arbiter_if.sv
// rtl/miriscv_mem_arbiter_if.sv - fetch, LSU and RAM signals seen by the memory arbiter
interface miriscv_mem_arbiter_if;

  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;

  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_mask_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_mask_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  // Arbiter side
  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_req_i, data_we_i, data_mask_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output mem_req_o, mem_we_o, mem_mask_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  // Core and RAM side
  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_req_i, data_we_i, data_mask_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  mem_req_o, mem_we_o, mem_mask_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/miriscv_rr_arb2.sv
// rtl/miriscv_rr_arb2.sv - two-way request picker; MIRISCV_ARB_DATA_PRIO_EN selects fixed data priority
module miriscv_rr_arb2
  import miriscv_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_gnt,
  output logic       o_ptr_nxt
);

`ifdef MIRISCV_ARB_DATA_PRIO_EN
  // Fixed priority: data wins any tie, pointer passes through untouched
  always_comb begin
    o_gnt = 2'b00;
    if (i_req[ARB_REQ_DATA]) begin
      o_gnt[ARB_REQ_DATA] = 1'b1;
    end else if (i_req[ARB_REQ_INSTR]) begin
      o_gnt[ARB_REQ_INSTR] = 1'b1;
    end
  end

  assign o_ptr_nxt = i_ptr;
`else
  // Round robin: a lone requester wins, a tie goes to the pointer, pointer moves to the loser
  always_comb begin
    o_gnt     = 2'b00;
    o_ptr_nxt = i_ptr;
    if (i_req[ARB_REQ_DATA] && (!i_req[ARB_REQ_INSTR] || (i_ptr == OWN_DATA))) begin
      o_gnt[ARB_REQ_DATA] = 1'b1;
      o_ptr_nxt           = OWN_INSTR;
    end else if (i_req[ARB_REQ_INSTR]) begin
      o_gnt[ARB_REQ_INSTR] = 1'b1;
      o_ptr_nxt            = OWN_DATA;
    end
  end
`endif

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// rtl/miriscv_mem_arbiter.sv - shares one RAM port between fetch and LSU; option MIRISCV_ARB_DATA_PRIO_EN
module miriscv_mem_arbiter
  import miriscv_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input logic                 clk,
  input logic                 reset,
  miriscv_mem_arbiter_if.slave bus
);

  arb_state_e           r_state;
  arb_owner_e           r_owner;
  logic [ARB_CNT_W-1:0] r_cnt;

  logic       w_slot;
  logic       w_resp;
  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_ptr;
  logic       w_ptr_nxt;

  // Response and issue slots are suppressed while reset is held so nothing leaks out
  assign w_resp = !reset && (r_state == ARB_BUSY) && (r_cnt == '0);
  assign w_slot = !reset && ((r_state == ARB_IDLE) || (r_cnt == '0));
  assign w_req  = w_slot ? {bus.data_req_i, bus.instr_req_i} : 2'b00;

  miriscv_rr_arb2 u_arb (
    .i_req     (w_req),
    .i_ptr     (w_ptr),
    .o_gnt     (w_gnt),
    .o_ptr_nxt (w_ptr_nxt)
  );

`ifdef MIRISCV_ARB_DATA_PRIO_EN
  assign w_ptr = OWN_DATA;
`else
  logic r_ptr;

  // Round-robin pointer, starts favouring data and flips to the loser on every grant
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= OWN_DATA;
    end else if (w_gnt != 2'b00) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  assign w_ptr = r_ptr;
`endif

  // Arbiter FSM: track the single outstanding access, its owner and cycles to response
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
      r_owner <= OWN_INSTR;
      r_cnt   <= '0;
    end else if (w_slot) begin
      if (w_gnt != 2'b00) begin
        r_state <= ARB_BUSY;
        r_owner <= w_gnt[ARB_REQ_DATA] ? OWN_DATA : OWN_INSTR;
        r_cnt   <= arb_cnt_init(MEM_LATENCY);
      end else begin
        r_state <= ARB_IDLE;
        r_cnt   <= '0;
      end
    end else begin
      r_cnt <= r_cnt - ARB_CNT_W'(1);
    end
  end

  // Grant, RAM request and response routing; idle buses are held at zero
  always_comb begin
    bus.instr_gnt_o    = w_gnt[ARB_REQ_INSTR];
    bus.data_gnt_o     = w_gnt[ARB_REQ_DATA];
    bus.mem_req_o      = 1'b0;
    bus.mem_we_o       = 1'b0;
    bus.mem_mask_o     = 4'b0000;
    bus.mem_addr_o     = '0;
    bus.mem_wdata_o    = '0;
    bus.instr_rvalid_o = 1'b0;
    bus.instr_rdata_o  = '0;
    bus.data_rvalid_o  = 1'b0;
    bus.data_rdata_o   = '0;

    if (w_gnt[ARB_REQ_DATA]) begin
      bus.mem_req_o   = 1'b1;
      bus.mem_we_o    = bus.data_we_i;
      bus.mem_mask_o  = bus.data_mask_i;
      bus.mem_addr_o  = bus.data_addr_i;
      bus.mem_wdata_o = bus.data_wdata_i;
    end else if (w_gnt[ARB_REQ_INSTR]) begin
      bus.mem_req_o  = 1'b1;
      bus.mem_addr_o = bus.instr_addr_i;
    end

    if (w_resp) begin
      if (r_owner == OWN_DATA) begin
        bus.data_rvalid_o = 1'b1;
        bus.data_rdata_o  = bus.mem_rdata_i;
      end else begin
        bus.instr_rvalid_o = 1'b1;
        bus.instr_rdata_o  = bus.mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// tb/tb_miriscv_mem_arbiter.sv - self-checking bench over MEM_LATENCY 1..4 with vectors and a reference model
module tb_miriscv_mem_arbiter;

  localparam int NL = 4;  // lane k runs with MEM_LATENCY = k+1

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NL-1:0]   ireq, dreq, dwe;
  logic [3:0]      dmask [NL];
  logic [31:0]     iaddr [NL];
  logic [31:0]     daddr [NL];
  logic [31:0]     wdata [NL];
  logic [31:0]     rdata;

  logic [NL-1:0]   o_gi, o_gd, o_rvi, o_rvd, o_mreq, o_mwe;
  logic [3:0]      o_mmask  [NL];
  logic [31:0]     o_maddr  [NL];
  logic [31:0]     o_mwdata [NL];
  logic [31:0]     o_irdata [NL];
  logic [31:0]     o_drdata [NL];

  for (genvar g = 0; g < NL; g++) begin : g_lane
    miriscv_mem_arbiter_if u_if ();

    miriscv_mem_arbiter #(.MEM_LATENCY(g + 1)) u_dut (
      .clk   (clk),
      .reset (rst),
      .bus   (u_if.slave)
    );

    assign u_if.instr_req_i  = ireq[g];
    assign u_if.instr_addr_i = iaddr[g];
    assign u_if.data_req_i   = dreq[g];
    assign u_if.data_we_i    = dwe[g];
    assign u_if.data_mask_i  = dmask[g];
    assign u_if.data_addr_i  = daddr[g];
    assign u_if.data_wdata_i = wdata[g];
    assign u_if.mem_rdata_i  = rdata;

    assign o_gi[g]     = u_if.instr_gnt_o;
    assign o_gd[g]     = u_if.data_gnt_o;
    assign o_rvi[g]    = u_if.instr_rvalid_o;
    assign o_rvd[g]    = u_if.data_rvalid_o;
    assign o_irdata[g] = u_if.instr_rdata_o;
    assign o_drdata[g] = u_if.data_rdata_o;
    assign o_mreq[g]   = u_if.mem_req_o;
    assign o_mwe[g]    = u_if.mem_we_o;
    assign o_mmask[g]  = u_if.mem_mask_o;
    assign o_maddr[g]  = u_if.mem_addr_o;
    assign o_mwdata[g] = u_if.mem_wdata_o;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input int lane, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s lane=%0d act=%h exp=%h t=%0t", nm, lane, act, exp, $time);
    end
  endtask

  // ---------------- reference model: absolute response times and last winner ----------------
  bit      m_busy   [NL];
  longint  m_due    [NL];
  bit      m_own_d  [NL];
  bit      m_we     [NL];
  bit      m_last_d [NL];
  bit      last_gi  [NL];
  bit      last_gd  [NL];
  longint  cyc = 0;

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < NL; k++) begin
        bit resp, slot, wi, wd;
        resp = m_busy[k] && (cyc == m_due[k]);
        slot = !m_busy[k] || resp;
        wi = 1'b0;
        wd = 1'b0;
        if (slot) begin
          if (ireq[k] && dreq[k]) begin
`ifdef MIRISCV_ARB_DATA_PRIO_EN
            wd = 1'b1;
`else
            wd = !m_last_d[k];
`endif
            wi = !wd;
          end else begin
            wi = ireq[k];
            wd = dreq[k];
          end
        end
        if (!rst) begin
          check("m_gnt_i", k, 32'(o_gi[k]), 32'(wi));
          check("m_gnt_d", k, 32'(o_gd[k]), 32'(wd));
          check("m_rv_i", k, 32'(o_rvi[k]), 32'(resp && !m_own_d[k]));
          check("m_rv_d", k, 32'(o_rvd[k]), 32'(resp && m_own_d[k]));
          check("m_mreq", k, 32'(o_mreq[k]), 32'(wi || wd));
          if (wi) begin
            check("m_mwe_i", k, 32'(o_mwe[k]), 32'd0);
            check("m_mmask_i", k, 32'(o_mmask[k]), 32'd0);
            check("m_maddr_i", k, o_maddr[k], iaddr[k]);
          end
          if (wd) begin
            check("m_mwe_d", k, 32'(o_mwe[k]), 32'(dwe[k]));
            check("m_mmask_d", k, 32'(o_mmask[k]), 32'(dmask[k]));
            check("m_maddr_d", k, o_maddr[k], daddr[k]);
            check("m_mwdata_d", k, o_mwdata[k], wdata[k]);
          end
          if (resp && !m_own_d[k]) begin
            check("m_rdata_i", k, o_irdata[k], rdata);
            check("m_rdata_d0", k, o_drdata[k], 32'd0);
          end
          if (resp && m_own_d[k]) begin
            if (!m_we[k]) check("m_rdata_d", k, o_drdata[k], rdata);
            check("m_rdata_i0", k, o_irdata[k], 32'd0);
          end
        end
        last_gi[k] = o_gi[k];
        last_gd[k] = o_gd[k];
        if (rst) begin
          m_busy[k]   = 1'b0;
          m_last_d[k] = 1'b0;
        end else if (wi || wd) begin
          m_busy[k]   = 1'b1;
          m_due[k]    = cyc + k + 1;
          m_own_d[k]  = wd;
          m_we[k]     = wd && dwe[k];
          m_last_d[k] = wd;
        end else if (slot) begin
          m_busy[k] = 1'b0;
        end
      end
      cyc++;
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    int          lane;
    bit          chk;
    bit          all0;
    bit          chk_rd;
    bit          rst, ir, dr, we;
    logic [3:0]  mask;
    logic [31:0] ia, da, wd, rd;
    bit          gi, gd, rvi, rvd, mreq, mwe;
    logic [3:0]  mmask;
    logic [31:0] maddr, mwdata, erd;
  } vec_t;

  function automatic vec_t mk(input int lane, input bit rst_v, input bit ir, input bit dr, input bit we,
                              input logic [3:0] mask, input logic [31:0] ia, input logic [31:0] da,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input bit gi, input bit gd, input bit rvi, input bit rvd,
                              input logic [31:0] maddr, input logic [31:0] erd, input bit chk_rd);
    vec_t v;
    v.lane = lane;  v.chk = !rst_v; v.all0 = 1'b0; v.chk_rd = chk_rd;
    v.rst = rst_v;  v.ir = ir; v.dr = dr; v.we = we; v.mask = mask;
    v.ia = ia; v.da = da; v.wd = wd; v.rd = rd;
    v.gi = gi; v.gd = gd; v.rvi = rvi; v.rvd = rvd;
    v.mreq   = gi || gd;
    v.mwe    = gd && we;
    v.mmask  = gd ? mask : 4'b0000;
    v.maddr  = maddr;
    v.mwdata = gd ? wd : 32'd0;
    v.erd    = erd;
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    vec_t v;
    rst   = 1'b1;
    ireq  = '0;
    dreq  = '0;
    dwe   = '0;
    rdata = '0;
    for (int k = 0; k < NL; k++) begin
      dmask[k] = '0; iaddr[k] = '0; daddr[k] = '0; wdata[k] = '0;
    end

    // single fetch at latency 1
    vt.push_back(mk(0, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 0, 0, 4'h0, 32'h100, 0, 0, 0, 1, 0, 0, 0, 32'h100, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 1, 0, 0, 32'hDEADBEEF, 1));
    // both requesters held for four accesses
`ifdef MIRISCV_ARB_DATA_PRIO_EN
    vt.push_back(mk(0, 0, 1, 1, 0, 4'hF, 32'h200, 32'h300, 0, 32'h11111111, 0, 1, 0, 0, 32'h300, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 0, 4'hF, 32'h200, 32'h300, 0, 32'h22222222, 0, 1, 0, 1, 32'h300, 32'h22222222, 1));
    vt.push_back(mk(0, 0, 1, 1, 0, 4'hF, 32'h200, 32'h300, 0, 32'h33333333, 0, 1, 0, 1, 32'h300, 32'h33333333, 1));
    vt.push_back(mk(0, 0, 1, 1, 0, 4'hF, 32'h200, 32'h300, 0, 32'h44444444, 0, 1, 0, 1, 32'h300, 32'h44444444, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 32'h55555555, 0, 0, 0, 1, 0, 32'h55555555, 1));
`else
    vt.push_back(mk(0, 0, 1, 1, 0, 4'hF, 32'h200, 32'h300, 0, 32'h11111111, 0, 1, 0, 0, 32'h300, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 0, 4'hF, 32'h200, 32'h300, 0, 32'h22222222, 1, 0, 0, 1, 32'h200, 32'h22222222, 1));
    vt.push_back(mk(0, 0, 1, 1, 0, 4'hF, 32'h200, 32'h300, 0, 32'h33333333, 0, 1, 1, 0, 32'h300, 32'h33333333, 1));
    vt.push_back(mk(0, 0, 1, 1, 0, 4'hF, 32'h200, 32'h300, 0, 32'h44444444, 1, 0, 0, 1, 32'h200, 32'h44444444, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 32'h55555555, 0, 0, 1, 0, 0, 32'h55555555, 1));
`endif
    // masked write, completion one cycle later
    vt.push_back(mk(0, 0, 0, 1, 1, 4'b0011, 0, 32'h20, 32'h1234ABCD, 0, 0, 1, 0, 0, 32'h20, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 32'h66666666, 0, 0, 0, 1, 0, 0, 0));
    // latency 3, continuous fetch: grant every third cycle, rvalid with next grant
    vt.push_back(mk(2, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(2, 0, 1, 0, 0, 4'h0, 32'h400, 0, 0, 32'hA0000001, 1, 0, 0, 0, 32'h400, 0, 0));
    vt.push_back(mk(2, 0, 1, 0, 0, 4'h0, 32'h400, 0, 0, 32'hA0000002, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(2, 0, 1, 0, 0, 4'h0, 32'h400, 0, 0, 32'hA0000003, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(2, 0, 1, 0, 0, 4'h0, 32'h404, 0, 0, 32'hA0000004, 1, 0, 1, 0, 32'h404, 32'hA0000004, 1));
    vt.push_back(mk(2, 0, 1, 0, 0, 4'h0, 32'h404, 0, 0, 32'hA0000005, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(2, 0, 1, 0, 0, 4'h0, 32'h404, 0, 0, 32'hA0000006, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(2, 0, 1, 0, 0, 4'h0, 32'h408, 0, 0, 32'hA0000007, 1, 0, 1, 0, 32'h408, 32'hA0000007, 1));
    // latency 2, reset on the cycle after grant abandons the access
    vt.push_back(mk(1, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 0, 1, 0, 0, 4'h0, 32'h500, 0, 0, 0, 1, 0, 0, 0, 32'h500, 0, 0));
    vt.push_back(mk(1, 1, 0, 0, 0, 4'h0, 0, 0, 0, 32'hBBBBBBBB, 0, 0, 0, 0, 0, 0, 0));
    v = mk(1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 32'hCCCCCCCC, 0, 0, 0, 0, 0, 0, 0);
    v.all0 = 1'b1;
    vt.push_back(v);
    v.rd = 32'hDDDDDDDD;
    vt.push_back(v);

    repeat (2) @(posedge clk);

    foreach (vt[i]) begin
      @(posedge clk);
      #1;
      rst   = vt[i].rst;
      rdata = vt[i].rd;
      for (int k = 0; k < NL; k++) begin
        ireq[k] = vt[i].ir;  dreq[k] = vt[i].dr;  dwe[k] = vt[i].we;
        dmask[k] = vt[i].mask; iaddr[k] = vt[i].ia; daddr[k] = vt[i].da; wdata[k] = vt[i].wd;
      end
      @(negedge clk);
      if (vt[i].chk) begin
        int l;
        l = vt[i].lane;
        check($sformatf("v%0d_gnt_i", i), l, 32'(o_gi[l]), 32'(vt[i].gi));
        check($sformatf("v%0d_gnt_d", i), l, 32'(o_gd[l]), 32'(vt[i].gd));
        check($sformatf("v%0d_rv_i", i), l, 32'(o_rvi[l]), 32'(vt[i].rvi));
        check($sformatf("v%0d_rv_d", i), l, 32'(o_rvd[l]), 32'(vt[i].rvd));
        check($sformatf("v%0d_mreq", i), l, 32'(o_mreq[l]), 32'(vt[i].mreq));
        if (vt[i].mreq || vt[i].all0) begin
          check($sformatf("v%0d_mwe", i), l, 32'(o_mwe[l]), 32'(vt[i].mwe));
          check($sformatf("v%0d_mmask", i), l, 32'(o_mmask[l]), 32'(vt[i].mmask));
          check($sformatf("v%0d_maddr", i), l, o_maddr[l], vt[i].maddr);
        end
        if (vt[i].gd || vt[i].all0)
          check($sformatf("v%0d_mwdata", i), l, o_mwdata[l], vt[i].mwdata);
        if (vt[i].rvi && vt[i].chk_rd)
          check($sformatf("v%0d_rdata_i", i), l, o_irdata[l], vt[i].erd);
        if (vt[i].rvd && vt[i].chk_rd)
          check($sformatf("v%0d_rdata_d", i), l, o_drdata[l], vt[i].erd);
        if (vt[i].all0) begin
          check($sformatf("v%0d_rdata_i0", i), l, o_irdata[l], 32'd0);
          check($sformatf("v%0d_rdata_d0", i), l, o_drdata[l], 32'd0);
        end
      end
    end

    // ---------------- randomized traffic, checked by the model ----------------
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      rst   = ($urandom_range(0, 199) == 0);
      rdata = $urandom;
      for (int k = 0; k < NL; k++) begin
        if (ireq[k] && !last_gi[k]) begin
          if ($urandom_range(0, 15) == 0) ireq[k] = 1'b0;
        end else begin
          ireq[k]  = $urandom_range(0, 1) == 1;
          iaddr[k] = $urandom & 32'hFFFF_FFFC;
        end
        if (dreq[k] && !last_gd[k]) begin
          if ($urandom_range(0, 15) == 0) dreq[k] = 1'b0;
        end else begin
          dreq[k]  = $urandom_range(0, 1) == 1;
          dwe[k]   = $urandom_range(0, 1) == 1;
          dmask[k] = 4'($urandom);
          daddr[k] = $urandom;
          wdata[k] = $urandom;
        end
      end
    end

    @(posedge clk);
    #1;
    ireq = '0;
    dreq = '0;
    repeat (6) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
